// File: rtl/pow2_reconstructor.sv
// Rebuilds a fixed-point word from a 1-based leading-one position and the mantissa bits below it.
// Two-stage elastic pipeline: s1 decodes one-hot/saturation, s2 shifts and optionally rounds.
module pow2_reconstructor #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int W_W    = 6,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_W-1:0]    w,
    input  logic [FRAC_W-1:0] frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_onehot,
    output logic              out_sat
);
    localparam int             WIDE_W = DATA_W + FRAC_W;
    localparam logic [W_W-1:0] W_MAX  = W_W'(DATA_W);

    // Handshake: a word moves on any edge where valid & ready are both high; a
    // stage advances when it is empty or the stage after it advances, so
    // out_ready reaches in_ready combinationally and a stalled stage holds.
    logic adv1;
    logic adv2;

    logic              s1_valid_q,  s1_valid_d;
    logic [W_W-1:0]    s1_w_q,      s1_w_d;
    logic [FRAC_W-1:0] s1_frac_q,   s1_frac_d;
    logic [DATA_W-1:0] s1_onehot_q, s1_onehot_d;
    logic              s1_sat_q,    s1_sat_d;

    logic              s2_valid_q,  s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,   s2_data_d;
    logic [DATA_W-1:0] s2_onehot_q, s2_onehot_d;
    logic              s2_sat_q,    s2_sat_d;

    logic              in_sat;
    logic [DATA_W-1:0] in_onehot;
    logic [W_W-1:0]    shamt;
    logic [WIDE_W-1:0] wide;
    logic              round_bit;
    logic [DATA_W-1:0] shifted;
    logic              unused_low;

    assign in_sat    = (w > W_MAX);
    assign in_onehot = (w == '0 || in_sat) ? '0 : (DATA_W'(1) << (w - 1'b1));

    // The mantissa sits FRAC_W bits above the binary point, so shifting by
    // w-1 and dropping the low FRAC_W bits gives both the left and right cases.
    assign shamt      = s1_w_q - 1'b1;
    assign wide       = WIDE_W'({1'b1, s1_frac_q}) << shamt;
    assign round_bit  = (ROUND != 0) ? wide[FRAC_W-1] : 1'b0;
    assign shifted    = wide[FRAC_W +: DATA_W] + DATA_W'(round_bit);
    assign unused_low = ^wide[FRAC_W-1:0];

    always_comb begin
        adv2 = !s2_valid_q || out_ready;
        adv1 = !s1_valid_q || adv2;

        s1_valid_d  = s1_valid_q;
        s1_w_d      = s1_w_q;
        s1_frac_d   = s1_frac_q;
        s1_onehot_d = s1_onehot_q;
        s1_sat_d    = s1_sat_q;
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_onehot_d = s2_onehot_q;
        s2_sat_d    = s2_sat_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_w_d      = w;
                s1_frac_d   = frac;
                s1_onehot_d = in_onehot;
                s1_sat_d    = in_sat;
            end
        end

        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_onehot_d = s1_onehot_q;
                s2_sat_d    = s1_sat_q;
                if (s1_sat_q) begin
                    s2_data_d = '1;
                end else if (s1_w_q == '0) begin
                    s2_data_d = '0;
                end else begin
                    s2_data_d = shifted;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_w_q      <= '0;
            s1_frac_q   <= '0;
            s1_onehot_q <= '0;
            s1_sat_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_onehot_q <= '0;
            s2_sat_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_w_q      <= s1_w_d;
            s1_frac_q   <= s1_frac_d;
            s1_onehot_q <= s1_onehot_d;
            s1_sat_q    <= s1_sat_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_onehot_q <= s2_onehot_d;
            s2_sat_q    <= s2_sat_d;
        end
    end

    assign in_ready   = adv1;
    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_onehot = s2_onehot_q;
    assign out_sat    = s2_sat_q;
endmodule

// File: tb/tb_pow2_reconstructor.sv
// Bench for pow2_reconstructor: one truncating and one rounding instance share the same stimulus.
`timescale 1ns/1ps
module tb_pow2_reconstructor;
    typedef logic [96:0] res_t;   // {sat, onehot, data_trunc, data_round}
    typedef struct {
        logic [5:0]  w;
        logic [15:0] frac;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] oh;
        logic        sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  w = '0;
    logic [15:0] frac = '0;
    logic        out_ready = 1'b0;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, out_sat0, out_sat1;
    logic [31:0] out_data0, out_data1, out_onehot0, out_onehot1;

    pow2_reconstructor #(.DATA_W(32), .FRAC_W(16), .W_W(6), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .w(w), .frac(frac),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_onehot(out_onehot0), .out_sat(out_sat0)
    );
    pow2_reconstructor #(.DATA_W(32), .FRAC_W(16), .W_W(6), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .w(w), .frac(frac),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_onehot(out_onehot1), .out_sat(out_sat1)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];
    logic prev_stall = 1'b0;
    res_t prev_a0, prev_a1;
    logic last_acc = 1'b0;
    vec_t tbl[10];

    function automatic res_t model(input logic [5:0] wi, input logic [15:0] fi);
        longint unsigned full, sh, v0, v1;
        int s;
        logic [31:0] oh;
        if (wi == 6'd0) return '0;
        if (wi > 6'd32) return {1'b1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        s    = int'(wi) - 1;
        full = 64'd65536 + 64'(fi);
        sh   = full << s;
        v0   = sh >> 16;
        v1   = (sh + 64'd32768) >> 16;
        oh   = 32'd1 << s;
        return {1'b0, oh, v0[31:0], v1[31:0]};
    endfunction

    task automatic check(input string name, input logic ok, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: observe at the falling edge, return 1ns after the rising edge.
    task automatic step();
        res_t a0, a1, e;
        @(negedge clk);
        last_acc = 1'b0;
        a0 = {out_sat0, out_onehot0, out_data0, out_data1};
        a1 = {out_sat1, out_onehot1, out_data0, out_data1};
        if (rst) begin
            if (prev_stall)
                check("stall_hold", out_valid0 && out_valid1 && a0 == prev_a0 && a1 == prev_a1,
                      128'(a0), 128'(prev_a0));
            check("ctrl_match", in_ready0 == in_ready1 && out_valid0 == out_valid1,
                  128'({in_ready1, out_valid1}), 128'({in_ready0, out_valid0}));
            if (in_valid && in_ready0) begin
                exp_q.push_back(model(w, frac));
                last_acc = 1'b1;
            end
            if (out_valid0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1'b0, 128'(a0), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result", a0 == e && a1 == e, 128'(a1 == e ? a0 : a1), 128'(e));
                end
            end
            prev_stall = out_valid0 && !out_ready;
            prev_a0    = a0;
            prev_a1    = a1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size() == 0, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tmo;
        tbl[0] = '{6'd0,  16'hABCD, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[1] = '{6'd1,  16'hFFFF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0};
        tbl[2] = '{6'd17, 16'h8000, 32'h0001_8000, 32'h0001_8000, 32'h0001_0000, 1'b0};
        tbl[3] = '{6'd32, 16'h0001, 32'h8000_8000, 32'h8000_8000, 32'h8000_0000, 1'b0};
        tbl[4] = '{6'd33, 16'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[5] = '{6'd63, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[6] = '{6'd16, 16'h8000, 32'h0000_C000, 32'h0000_C000, 32'h0000_8000, 1'b0};
        tbl[7] = '{6'd2,  16'h4000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0002, 1'b0};
        tbl[8] = '{6'd9,  16'h00FF, 32'h0000_0100, 32'h0000_0101, 32'h0000_0100, 1'b0};
        tbl[9] = '{6'd24, 16'h0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", !out_valid0 && !out_valid1 && out_data0 == 0 && out_data1 == 0 &&
              out_onehot0 == 0 && !out_sat0 && !out_sat1 && in_ready0 && in_ready1,
              128'({out_valid0, out_sat0, in_ready0, out_data0, out_onehot0}), 128'({3'b001, 64'h0}));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, two-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = tbl[i].w;
            frac = tbl[i].frac;
            in_valid = 1'b1;
            step();
            check("tbl_accept", last_acc, 128'(last_acc), 128'(1));
            in_valid = 1'b0;
            step();
            check($sformatf("tbl%0d", i),
                  out_valid0 && out_valid1 && out_data0 == tbl[i].d0 && out_data1 == tbl[i].d1 &&
                  out_onehot0 == tbl[i].oh && out_onehot1 == tbl[i].oh &&
                  out_sat0 == tbl[i].sat && out_sat1 == tbl[i].sat,
                  128'({out_valid0, out_sat0, out_onehot0, out_data0, out_data1}),
                  128'({1'b1, tbl[i].sat, tbl[i].oh, tbl[i].d0, tbl[i].d1}));
            step();
        end

        // Backpressure: three back-to-back inputs against a stalled output
        out_ready = 1'b0;
        w = 6'd20; frac = 16'h1357; in_valid = 1'b1;
        step();
        check("bp_acc0", last_acc, 128'(last_acc), 128'(1));
        w = 6'd5; frac = 16'hC001;
        step();
        check("bp_acc1", last_acc, 128'(last_acc), 128'(1));
        check("bp_in_ready_low", !in_ready0 && !in_ready1, 128'({in_ready0, in_ready1}), 128'(0));
        w = 6'd40; frac = 16'h2468;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_no_accept", !last_acc && out_valid0, 128'({last_acc, out_valid0}), 128'(1));
        end
        out_ready = 1'b1;
        tmo = 0;
        do begin
            step();
            tmo++;
        end while (!last_acc && tmo < 20);
        check("bp_acc2", last_acc, 128'(tmo), 128'(1));
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            if (!(in_valid && !last_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                w = 6'($urandom_range(0, 63));
                frac = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Full-rate streaming, then reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            w = 6'($urandom_range(0, 40));
            frac = 16'($urandom);
            step();
            check("full_rate", last_acc && in_ready0 && (i == 0 || out_valid0),
                  128'({last_acc, in_ready0, out_valid0}), 128'(3'b111));
        end
        rst = 1'b0;
        #1;
        check("rst_async", !out_valid0 && !out_valid1 && out_data0 == 0 && out_onehot0 == 0 && !out_sat0,
              128'({out_valid0, out_valid1, out_sat0, out_data0}), 128'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_release", in_ready0 && in_ready1 && !out_valid0,
              128'({in_ready0, in_ready1, out_valid0}), 128'(3'b110));
        @(posedge clk);
        #1;
        w = 6'd17; frac = 16'h8000; in_valid = 1'b1;
        step();
        check("post_rst_accept", last_acc, 128'(last_acc), 128'(1));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
